i2c_reg_arbiter: RTL and testbench

//  Shares one register-bank port between the I2C slave transaction interface and an on-chip host.

---
 rtl/i2c_reg_arbiter_if.sv | 58 +++++
 rtl/i2c_reg_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_arbiter_if.sv
// Interface bundling the three sides of the register-port arbiter:
//   I2C side  : i2c_req/op/addr/wdata in, i2c_rdata/done/err/ovf out, i2c_ovf_clr in
//   Host side : host_req/we/addr/wdata in, host_rdata/ack/err out
//   Bus side  : reg_en/we/addr/wdata out, reg_rdata/reg_ack in
// Modport slave is the arbiter's view; modport master is the view of the surrounding logic
// (I2C slave, host and register bank) that talks to it.
interface i2c_reg_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) ();

  // I2C transaction side
  logic              i2c_req;
  logic              i2c_op;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic [DATA_W-1:0] i2c_rdata;
  logic              i2c_done;
  logic              i2c_err;
  logic              i2c_ovf;
  logic              i2c_ovf_clr;

  // On-chip host side
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic              host_err;

  // Register bank side
  logic              reg_en;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  modport slave (
    input  i2c_req, i2c_op, i2c_addr, i2c_wdata, i2c_ovf_clr,
    output i2c_rdata, i2c_done, i2c_err, i2c_ovf,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack, host_err,
    output reg_en, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport master (
    output i2c_req, i2c_op, i2c_addr, i2c_wdata, i2c_ovf_clr,
    input  i2c_rdata, i2c_done, i2c_err, i2c_ovf,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack, host_err,
    input  reg_en, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/i2c_reg_arbiter.sv
// Shares one register-bank port between the I2C slave transaction interface and an on-chip
// host. Single-cycle I2C requests are captured in a one-deep pending register; host requests
// are level req/ack. One bus transaction runs at a time (IDLE -> BUS -> DONE), each waiting
// for reg_ack or aborting after TIMEOUT bus cycles with all-ones read data and err=1.
// A streak counter stops a busy I2C master from starving a waiting host.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - i2c_reg_arbiter_if.slave: I2C side, host side and register bank side
module i2c_reg_arbiter #(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned MAX_I2C_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  i2c_reg_arbiter_if.slave  bus
);

  localparam int unsigned TcntW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned StreakW = $clog2(MAX_I2C_STREAK + 1);

  localparam logic [TcntW-1:0]   TcntMax   = TcntW'(TIMEOUT - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_I2C_STREAK);

  localparam logic OwnI2c  = 1'b0;
  localparam logic OwnHost = 1'b1;

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;

  // Pending I2C request
  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic              i2c_ovf_q, i2c_ovf_d;

  logic [StreakW-1:0] streak_q, streak_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;

  // Bus command registers, loaded at grant and held through BUS
  logic              reg_we_q, reg_we_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

  // Per-owner results, held until that owner's next completion
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic              i2c_err_q, i2c_err_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_err_q, host_err_d;

  logic              bus_finish;
  logic [DATA_W-1:0] result_rdata;
  logic              result_err;
  logic              pend_clear;
  logic              i2c_drop;

  // Arbitration and transaction FSM
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    tcnt_d       = tcnt_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    i2c_rdata_d  = i2c_rdata_q;
    i2c_err_d    = i2c_err_q;
    host_rdata_d = host_rdata_q;
    host_err_d   = host_err_q;
    bus_finish   = 1'b0;
    result_rdata = bus.reg_rdata;
    result_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.host_req) begin
          streak_d = '0;
        end
        // I2C wins a tie unless it has already taken MAX_I2C_STREAK grants in a row
        if (pend_q && (!bus.host_req || (streak_q != StreakMax))) begin
          owner_d     = OwnI2c;
          reg_we_d    = pend_we_q;
          reg_addr_d  = pend_addr_q;
          reg_wdata_d = pend_wdata_q;
          tcnt_d      = '0;
          state_d     = StBus;
          if (bus.host_req) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (bus.host_req) begin
          owner_d     = OwnHost;
          reg_we_d    = bus.host_we;
          reg_addr_d  = bus.host_addr;
          reg_wdata_d = bus.host_wdata;
          tcnt_d      = '0;
          streak_d    = '0;
          state_d     = StBus;
        end
      end

      StBus: begin
        if (bus.reg_ack) begin
          bus_finish   = 1'b1;
          result_rdata = bus.reg_rdata;
          result_err   = 1'b0;
        end else if (tcnt_q == TcntMax) begin
          bus_finish   = 1'b1;
          result_rdata = {DATA_W{1'b1}};
          result_err   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end

        if (bus_finish) begin
          state_d = StDone;
          if (owner_q == OwnHost) begin
            host_rdata_d = result_rdata;
            host_err_d   = result_err;
          end else begin
            i2c_rdata_d = result_rdata;
            i2c_err_d   = result_err;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // I2C request capture; the slot frees on entry to DONE, so a request in that same
  // cycle is accepted rather than dropped.
  always_comb begin
    pend_clear   = bus_finish && (owner_q == OwnI2c);
    i2c_drop     = bus.i2c_req && pend_q && !pend_clear;
    pend_d       = pend_q && !pend_clear;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;

    if (bus.i2c_req && !i2c_drop) begin
      pend_d       = 1'b1;
      pend_we_d    = bus.i2c_op;
      pend_addr_d  = bus.i2c_addr;
      pend_wdata_d = bus.i2c_wdata;
    end

    // A new overflow beats a simultaneous clear
    if (i2c_drop) begin
      i2c_ovf_d = 1'b1;
    end else if (bus.i2c_ovf_clr) begin
      i2c_ovf_d = 1'b0;
    end else begin
      i2c_ovf_d = i2c_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnI2c;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      i2c_ovf_q    <= 1'b0;
      streak_q     <= '0;
      tcnt_q       <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      i2c_rdata_q  <= '0;
      i2c_err_q    <= 1'b0;
      host_rdata_q <= '0;
      host_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      i2c_ovf_q    <= i2c_ovf_d;
      streak_q     <= streak_d;
      tcnt_q       <= tcnt_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      i2c_rdata_q  <= i2c_rdata_d;
      i2c_err_q    <= i2c_err_d;
      host_rdata_q <= host_rdata_d;
      host_err_q   <= host_err_d;
    end
  end

  assign bus.reg_en     = (state_q == StBus);
  assign bus.reg_we     = reg_we_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;

  assign bus.i2c_done   = (state_q == StDone) && (owner_q == OwnI2c);
  assign bus.i2c_rdata  = i2c_rdata_q;
  assign bus.i2c_err    = i2c_err_q;
  assign bus.i2c_ovf    = i2c_ovf_q;

  assign bus.host_ack   = (state_q == StDone) && (owner_q == OwnHost);
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_err   = host_err_q;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Self-checking bench for i2c_reg_arbiter: a table of single transactions (I2C and host,
// various ack delays and timeouts) plus hand-written sequences for arbitration fairness,
// overflow handling, same-cycle accept and reset during a bus transaction.
module tb_i2c_reg_arbiter;

  localparam int unsigned ADDR_W         = 11;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned TIMEOUT        = 16;
  localparam int unsigned MAX_I2C_STREAK = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  i2c_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  i2c_reg_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT        (TIMEOUT),
    .MAX_I2C_STREAK (MAX_I2C_STREAK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        host;       // 1 = host transaction, 0 = I2C
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wdata;
    int          ack_delay;  // BUS cycle index carrying reg_ack; 255 = never
    logic [7:0]  bus_rdata;
    int          exp_bus;    // expected number of cycles with reg_en=1
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  logic [7:0] last_i2c_rdata;
  logic [7:0] last_host_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i2c_req     = 1'b0;
    bus.i2c_op      = 1'b0;
    bus.i2c_addr    = '0;
    bus.i2c_wdata   = '0;
    bus.i2c_ovf_clr = 1'b0;
    bus.host_req    = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.reg_rdata   = '0;
    bus.reg_ack     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   n_bus;
    logic got;
    if (!v.host) begin
      bus.i2c_req   = 1'b1;
      bus.i2c_op    = v.we;
      bus.i2c_addr  = v.addr;
      bus.i2c_wdata = v.wdata;
      step();
      bus.i2c_req = 1'b0;
      check($sformatf("v%0d_pend_no_bus", idx), bus.reg_en, 1'b0);
      step();
    end else begin
      bus.host_req   = 1'b1;
      bus.host_we    = v.we;
      bus.host_addr  = v.addr;
      bus.host_wdata = v.wdata;
      step();
    end
    check($sformatf("v%0d_reg_en", idx), bus.reg_en, 1'b1);
    check($sformatf("v%0d_reg_we", idx), bus.reg_we, v.we);
    check($sformatf("v%0d_reg_addr", idx), bus.reg_addr, v.addr);
    check($sformatf("v%0d_reg_wdata", idx), bus.reg_wdata, v.wdata);

    n_bus = 0;
    got   = 1'b0;
    for (int k = 0; k < int'(TIMEOUT) + 4 && !got; k++) begin
      if (bus.reg_en) n_bus++;
      bus.reg_ack   = (k == v.ack_delay);
      bus.reg_rdata = v.bus_rdata;
      step();
      bus.reg_ack = 1'b0;
      got = v.host ? bus.host_ack : bus.i2c_done;
    end
    bus.host_req = 1'b0;
    check($sformatf("v%0d_done_seen", idx), got, 1'b1);
    check($sformatf("v%0d_other_quiet", idx), v.host ? bus.i2c_done : bus.host_ack, 1'b0);
    check($sformatf("v%0d_bus_cycles", idx), n_bus, v.exp_bus);
    check($sformatf("v%0d_en_in_done", idx), bus.reg_en, 1'b0);
    check($sformatf("v%0d_rdata", idx), v.host ? bus.host_rdata : bus.i2c_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", idx), v.host ? bus.host_err : bus.i2c_err, v.exp_err);
    if (v.host) begin
      check($sformatf("v%0d_i2c_rdata_held", idx), bus.i2c_rdata, last_i2c_rdata);
      last_host_rdata = v.exp_rdata;
    end else begin
      check($sformatf("v%0d_host_rdata_held", idx), bus.host_rdata, last_host_rdata);
      last_i2c_rdata = v.exp_rdata;
    end
    step();
    check($sformatf("v%0d_pulse_1cyc", idx), {bus.i2c_done, bus.host_ack}, 2'b00);
  endtask

  initial begin
    logic [7:0] seq;
    int         n_ev;
    logic       stray;

    //             host  we    addr     wdata  ack  bus_rd exp_bus exp_rd err
    vecs[0] = '{1'b0, 1'b1, 11'h155, 8'hA5, 0,   8'h5A, 1,  8'h5A, 1'b0};  // I2C write
    vecs[1] = '{1'b1, 1'b0, 11'h010, 8'h00, 2,   8'h3C, 3,  8'h3C, 1'b0};  // host read
    vecs[2] = '{1'b0, 1'b0, 11'h7FF, 8'h00, 255, 8'h12, 16, 8'hFF, 1'b1};  // I2C timeout
    vecs[3] = '{1'b1, 1'b1, 11'h2AA, 8'h33, 0,   8'h00, 1,  8'h00, 1'b0};  // host write
    vecs[4] = '{1'b1, 1'b0, 11'h001, 8'h00, 255, 8'h77, 16, 8'hFF, 1'b1};  // host timeout
    vecs[5] = '{1'b0, 1'b0, 11'h000, 8'h00, 15,  8'hC3, 16, 8'hC3, 1'b0};  // ack on last cycle
    vecs[6] = '{1'b0, 1'b0, 11'h400, 8'h00, 5,   8'h81, 6,  8'h81, 1'b0};  // I2C read

    last_i2c_rdata  = 8'h00;
    last_host_rdata = 8'h00;

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_outputs",
          {bus.reg_en, bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.i2c_done, bus.i2c_err,
           bus.i2c_ovf, bus.i2c_rdata, bus.host_ack, bus.host_err, bus.host_rdata}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Fairness: host waits while I2C requests arrive every 3 cycles
    bus.reg_ack   = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 11'h0AA;
    seq  = '0;
    n_ev = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 1) bus.host_req = 1'b1;
      bus.i2c_req  = ((c % 3) == 0) && (c < 18);
      bus.i2c_op   = 1'b0;
      bus.i2c_addr = 11'(32'h100 + c);
      step();
      bus.i2c_req = 1'b0;
      if (bus.i2c_done) begin
        seq = {seq[6:0], 1'b0};
        n_ev++;
      end
      if (bus.host_ack) begin
        seq = {seq[6:0], 1'b1};
        n_ev++;
        bus.host_req = 1'b0;
      end
    end
    bus.reg_ack = 1'b0;
    check("streak_events", n_ev, 6);
    check("streak_order", seq[5:0], 6'b000010);
    check("streak_drop_ovf", bus.i2c_ovf, 1'b1);
    bus.i2c_ovf_clr = 1'b1;
    step();
    bus.i2c_ovf_clr = 1'b0;
    check("streak_ovf_clr", bus.i2c_ovf, 1'b0);

    // Overflow while the bus is busy with a host read; host_req dropped mid-transaction
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 11'h020;
    bus.reg_rdata = 8'h6E;
    step();                                     // c1 BUS (host)
    check("ovf_host_bus", bus.reg_en, 1'b1);
    bus.i2c_req   = 1'b1;
    bus.i2c_op    = 1'b1;
    bus.i2c_addr  = 11'h0C1;
    bus.i2c_wdata = 8'h11;
    step();                                     // c2: first request now pending
    bus.host_req  = 1'b0;
    bus.i2c_addr  = 11'h0C2;
    bus.i2c_wdata = 8'h22;
    step();                                     // c3: second dropped
    bus.i2c_req = 1'b0;
    check("ovf_set", bus.i2c_ovf, 1'b1);
    step();                                     // c4
    check("ovf_held", bus.i2c_ovf, 1'b1);
    bus.i2c_req     = 1'b1;
    bus.i2c_addr    = 11'h0C3;
    bus.i2c_ovf_clr = 1'b1;
    step();                                     // c5
    bus.i2c_req = 1'b0;
    check("ovf_set_wins", bus.i2c_ovf, 1'b1);
    step();                                     // c6: clear alone
    bus.i2c_ovf_clr = 1'b0;
    check("ovf_cleared", bus.i2c_ovf, 1'b0);
    bus.reg_ack = 1'b1;
    step();                                     // c7 DONE (host)
    bus.reg_ack = 1'b0;
    check("ovf_host_ack", bus.host_ack, 1'b1);
    check("ovf_host_rdata", bus.host_rdata, 8'h6E);
    check("ovf_host_err", bus.host_err, 1'b0);
    step();                                     // c8 IDLE, grant pending I2C
    step();                                     // c9 BUS
    check("ovf_first_kept", {bus.reg_en, bus.reg_we, bus.reg_addr, bus.reg_wdata},
          {1'b1, 1'b1, 11'h0C1, 8'h11});
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 8'h44;
    step();
    bus.reg_ack = 1'b0;
    check("ovf_i2c_done", {bus.i2c_done, bus.i2c_rdata}, {1'b1, 8'h44});
    step();

    // Request in the same cycle the pending slot clears is accepted
    bus.i2c_req  = 1'b1;
    bus.i2c_op   = 1'b0;
    bus.i2c_addr = 11'h0A1;
    step();
    bus.i2c_req = 1'b0;
    step();                                     // BUS
    check("same_cyc_bus_addr", bus.reg_addr, 11'h0A1);
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 8'h99;
    bus.i2c_req   = 1'b1;
    bus.i2c_addr  = 11'h0B2;
    step();                                     // DONE
    bus.reg_ack = 1'b0;
    bus.i2c_req = 1'b0;
    check("same_cyc_done", bus.i2c_done, 1'b1);
    check("same_cyc_no_ovf", bus.i2c_ovf, 1'b0);
    step();                                     // IDLE grant
    step();                                     // BUS
    check("same_cyc_second", {bus.reg_en, bus.reg_addr}, {1'b1, 11'h0B2});
    bus.reg_ack = 1'b1;
    step();
    bus.reg_ack = 1'b0;
    check("same_cyc_second_done", bus.i2c_done, 1'b1);
    step();

    // Reset during BUS abandons the transaction
    bus.i2c_req  = 1'b1;
    bus.i2c_addr = 11'h0D4;
    step();
    bus.i2c_req = 1'b0;
    step();
    check("rst_mid_bus", bus.reg_en, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_reg_en", bus.reg_en, 1'b0);
    check("rst_rdata_cleared", bus.i2c_rdata, 8'h00);
    stray = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stray = stray | bus.reg_en | bus.i2c_done | bus.host_ack;
      step();
    end
    check("rst_no_completion", stray, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
